// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-bus initiator.
// Holds the FSM state encoding and the address-to-select decode helper.
// The state encoding uses plain localparams so that legacy tools and
// waveform viewers see stable numeric codes.
package reg_bus_pkg;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StSelect  = 3'd1;
    localparam logic [2:0] StCapture = 3'd2;
    localparam logic [2:0] StWrite   = 3'd3;
    localparam logic [2:0] StRespond = 3'd4;

    // Largest register count the fabric supports.
    localparam int unsigned MaxRegs = 16;

    // One bit of the one-hot-low select decode.
    // Returns 0 (selected) when addr targets register idx, else 1.
    function automatic logic decode_cs_bit(input int unsigned addr, input int unsigned idx);
        return (addr != idx);
    endfunction

endpackage

// File: rtl/reg_bus_controller_if.sv
// Bundle of request/response handshake and shared register-bus signals.
//   master : requester side (drives requests, consumes responses, resolves bus_rdata)
//   slave  : controller side (accepts requests, drives cs/reg_ce/bus_wdata)
// Signals:
//   req_valid/req_ready/req_write/req_addr/req_wdata : request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err            : response channel
//   cs (active-low select), reg_ce (write enable), bus_wdata, bus_rdata
interface reg_bus_controller_if #(
    parameter int unsigned NrOfBits = 32,
    parameter int unsigned NrOfRegs = 4,
    parameter int unsigned AddrBits = 2
);
    logic                req_valid;
    logic                req_ready;
    logic                req_write;
    logic [AddrBits-1:0] req_addr;
    logic [NrOfBits-1:0] req_wdata;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [NrOfBits-1:0] rsp_rdata;
    logic                rsp_err;

    logic [NrOfRegs-1:0] cs;
    logic [NrOfRegs-1:0] reg_ce;
    logic [NrOfBits-1:0] bus_wdata;
    logic [NrOfBits-1:0] bus_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, bus_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, cs, reg_ce, bus_wdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, bus_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, cs, reg_ce, bus_wdata
    );

endinterface

// File: rtl/reg_bus_decoder.sv
// Combinational address decoder for the shared register bus.
// Ports:
//   addr     : register index
//   enable   : allow any select/enable to assert
//   cs       : per-register select, active-low one-hot (all ones when idle)
//   reg_ce   : per-register write enable, active-high one-hot or zero
//   addr_err : addr is outside the populated register range
module reg_bus_decoder
    import reg_bus_pkg::*;
#(
    parameter int unsigned NrOfRegs = 4,
    parameter int unsigned AddrBits = 2
) (
    input  logic [AddrBits-1:0] addr,
    input  logic                enable,
    output logic [NrOfRegs-1:0] cs,
    output logic [NrOfRegs-1:0] reg_ce,
    output logic                addr_err
);

    assign addr_err = (32'(addr) >= NrOfRegs);

    always_comb begin
        cs     = '1;
        reg_ce = '0;
        for (int unsigned i = 0; i < NrOfRegs; i++) begin
            if (enable && !addr_err) begin
                cs[i]     = decode_cs_bit(32'(addr), i);
                reg_ce[i] = !decode_cs_bit(32'(addr), i);
            end
        end
    end

endmodule

// File: rtl/reg_bus_controller.sv
// Initiator for the shared tri-state register bus.
// Accepts one read or write request at a time and returns a single response.
// Reads drive the target cs low, wait SettleCycles, capture bus_rdata.
// Writes hold reg_ce for the target until a Tick-qualified edge commits it.
// Ports:
//   Clock  : system clock
//   Reset  : asynchronous active-low reset
//   Tick   : global clock-enable; a write commits on an edge where Tick=1
//   bus    : request/response handshake plus cs/reg_ce/bus_wdata/bus_rdata
module reg_bus_controller
    import reg_bus_pkg::*;
#(
    parameter int unsigned NrOfBits     = 32,
    parameter int unsigned NrOfRegs     = 4,
    parameter int unsigned AddrBits     = 2,
    parameter int unsigned SettleCycles = 1
) (
    input logic                Clock,
    input logic                Reset,
    input logic                Tick,
    reg_bus_controller_if.slave bus
);

    localparam logic [2:0] SettleLoad = 3'(SettleCycles - 1);

    logic [2:0]          state_q, state_d;
    logic [AddrBits-1:0] addr_q;
    logic [AddrBits-1:0] dec_addr;
    logic [2:0]          settle_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [NrOfBits-1:0] rsp_rdata_q;
    logic [NrOfBits-1:0] bus_wdata_q;

    logic                accept;
    logic                dec_en;
    logic                dec_err;
    logic                selecting;
    logic [NrOfRegs-1:0] dec_cs;
    logic [NrOfRegs-1:0] dec_ce;

    // req_ready is only high in IDLE, so accept implies IDLE.
    assign accept = bus.req_valid & req_ready_q;

    // In IDLE the decoder looks at the incoming address so the range check is
    // available at the accepting edge; afterwards it follows the latched one.
    assign dec_addr  = (state_q == StIdle) ? bus.req_addr : addr_q;
    assign dec_en    = (state_q == StSelect) || (state_q == StCapture) ||
                       (state_q == StWrite);
    assign selecting = (state_q == StSelect) || (state_q == StCapture);

    reg_bus_decoder #(
        .NrOfRegs (NrOfRegs),
        .AddrBits (AddrBits)
    ) u_decoder (
        .addr     (dec_addr),
        .enable   (dec_en),
        .cs       (dec_cs),
        .reg_ce   (dec_ce),
        .addr_err (dec_err)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (dec_err) begin
                        state_d = StRespond;
                    end else if (bus.req_write) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StSelect;
                    end
                end
            end
            StSelect: begin
                if (settle_q == 3'd0) begin
                    state_d = StCapture;
                end
            end
            StCapture: state_d = StRespond;
            StWrite: begin
                if (Tick) begin
                    state_d = StRespond;
                end
            end
            StRespond: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            settle_q    <= 3'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == StIdle);
            rsp_valid_q <= (state_d == StRespond);

            if (accept) begin
                addr_q      <= bus.req_addr;
                settle_q    <= SettleLoad;
                rsp_rdata_q <= '0;
                rsp_err_q   <= dec_err;
                // Register D inputs keep the last written value between writes.
                if (bus.req_write && !dec_err) begin
                    bus_wdata_q <= bus.req_wdata;
                end
            end else begin
                if ((state_q == StSelect) && (settle_q != 3'd0)) begin
                    settle_q <= settle_q - 3'd1;
                end
                if (state_q == StCapture) begin
                    rsp_rdata_q <= bus.bus_rdata;
                end
            end
        end
    end

    // Selects and enables come straight from state so an async reset clears
    // them immediately; cs and reg_ce are never active in the same state.
    assign bus.cs        = selecting ? dec_cs : '1;
    assign bus.reg_ce    = (state_q == StWrite) ? dec_ce : '0;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_reg_bus_controller.sv
// Bench for reg_bus_controller: two instances (4 regs / settle 1 and
// 3 regs / settle 3) on emulated register banks, checked against an array
// model of register contents and the protocol timing rules.
module tb_reg_bus_controller;

    localparam int SettleA = 1;
    localparam int SettleB = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic tick = 1'b1;
    int   tick_period = 0;
    int   tick_cnt = 0;
    bit   env_init = 1'b1;

    int n_tests = 0;
    int n_fail = 0;
    int viol = 0;

    logic [31:0] env_a [4];
    logic [31:0] env_b [3];
    logic [31:0] model_a [4];
    logic [31:0] model_b [3];

    always #5 clk = ~clk;

    reg_bus_controller_if #(.NrOfBits(32), .NrOfRegs(4), .AddrBits(2)) ifa ();
    reg_bus_controller_if #(.NrOfBits(32), .NrOfRegs(3), .AddrBits(2)) ifb ();

    reg_bus_controller #(
        .NrOfBits(32), .NrOfRegs(4), .AddrBits(2), .SettleCycles(SettleA)
    ) dut_a (
        .Clock(clk), .Reset(rst_n), .Tick(tick), .bus(ifa.slave)
    );

    reg_bus_controller #(
        .NrOfBits(32), .NrOfRegs(3), .AddrBits(2), .SettleCycles(SettleB)
    ) dut_b (
        .Clock(clk), .Reset(rst_n), .Tick(tick), .bus(ifb.slave)
    );

    // Tick for the next edge is set well before the sampling negedge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            tick_cnt++;
            tick = (tick_period == 0) ? 1'b1 : ((tick_cnt % tick_period) == 0);
        end
    end

    // Emulated registers: load on ClockEnable qualified by Tick.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (env_init) env_a[i] <= 32'h0;
            else if (ifa.reg_ce[i] && tick) env_a[i] <= ifa.bus_wdata;
        end
        for (int i = 0; i < 3; i++) begin
            if (env_init) env_b[i] <= 32'h0;
            else if (ifb.reg_ce[i] && tick) env_b[i] <= ifb.bus_wdata;
        end
    end

    // Tri-state resolution: only a register with cs low drives the bus.
    always_comb begin
        ifa.bus_rdata = 32'h0;
        for (int i = 0; i < 4; i++) if (!ifa.cs[i]) ifa.bus_rdata = env_a[i];
    end
    always_comb begin
        ifb.bus_rdata = 32'h0;
        for (int i = 0; i < 3; i++) if (!ifb.cs[i]) ifb.bus_rdata = env_b[i];
    end

    // Bus-level invariants, tallied and judged in test_protocol.
    always @(negedge clk) begin
        if (rst_n) begin
            if ($countones(~ifa.cs) > 1 || $countones(ifa.reg_ce) > 1 ||
                (ifa.reg_ce != 0 && ifa.cs != 4'hF)) viol++;
            if ($countones(~ifb.cs) > 1 || $countones(ifb.reg_ce) > 1 ||
                (ifb.reg_ce != 0 && ifb.cs != 3'h7)) viol++;
        end
    end

    function automatic logic [3:0] cs_of(input int sel);
        return (sel == 0) ? ifa.cs : {1'b0, ifb.cs};
    endfunction
    function automatic logic [3:0] ce_of(input int sel);
        return (sel == 0) ? ifa.reg_ce : {1'b0, ifb.reg_ce};
    endfunction
    function automatic logic rdy_of(input int sel);
        return (sel == 0) ? ifa.req_ready : ifb.req_ready;
    endfunction
    function automatic logic vld_of(input int sel);
        return (sel == 0) ? ifa.rsp_valid : ifb.rsp_valid;
    endfunction
    function automatic logic err_of(input int sel);
        return (sel == 0) ? ifa.rsp_err : ifb.rsp_err;
    endfunction
    function automatic logic [31:0] rdata_of(input int sel);
        return (sel == 0) ? ifa.rsp_rdata : ifb.rsp_rdata;
    endfunction
    function automatic logic [31:0] wdata_of(input int sel);
        return (sel == 0) ? ifa.bus_wdata : ifb.bus_wdata;
    endfunction

    task automatic drive(input int sel, input logic v, input logic w, input logic [1:0] a,
                         input logic [31:0] d);
        if (sel == 0) begin
            ifa.req_valid = v; ifa.req_write = w; ifa.req_addr = a; ifa.req_wdata = d;
        end else begin
            ifb.req_valid = v; ifb.req_write = w; ifb.req_addr = a; ifb.req_wdata = d;
        end
    endtask

    task automatic set_rsp_ready(input int sel, input logic r);
        if (sel == 0) ifa.rsp_ready = r;
        else ifb.rsp_ready = r;
    endtask

    // One complete transaction with per-cycle protocol checks.
    task automatic run_txn(input int sel, input logic w, input logic [1:0] a,
                           input logic [31:0] d, input int hold);
        int          settle, nregs, lat, wcyc, bound;
        bit          is_err, tick_early, last_tick;
        logic [3:0]  all1, exp_cs, exp_ce;
        logic [31:0] exp_rdata;
        settle = (sel == 0) ? SettleA : SettleB;
        nregs  = (sel == 0) ? 4 : 3;
        all1   = (sel == 0) ? 4'hF : 4'h7;
        is_err = (int'(a) >= nregs);
        exp_ce = 4'b0001 << a;
        exp_cs = all1 & ~exp_ce;
        exp_rdata = 32'h0;
        if (!w && !is_err) exp_rdata = (sel == 0) ? model_a[a] : model_b[a];

        @(negedge clk);
        drive(sel, 1'b1, w, a, d);
        set_rsp_ready(sel, hold == 0);
        bound = 0;
        while (rdy_of(sel) !== 1'b1 && bound < 20) begin
            @(negedge clk);
            bound++;
        end
        n_tests++;
        if (rdy_of(sel) !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_timeout: req_ready=%b required 1", rdy_of(sel));
            drive(sel, 1'b0, 1'b0, 2'd0, 32'h0);
            return;
        end
        @(posedge clk);
        #1 drive(sel, 1'b0, 1'($urandom), 2'($urandom), $urandom);

        lat = 0; wcyc = 0; tick_early = 0; last_tick = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (vld_of(sel) === 1'b1) break;
            n_tests++;
            if (is_err) begin
                n_fail++;
                $display("FAIL err_latency: rsp_valid=0 at cycle %0d required 1 at cycle 1", lat);
            end else if (!w) begin
                if (cs_of(sel) !== exp_cs || ce_of(sel) !== 4'h0) begin
                    n_fail++;
                    $display("FAIL read_select: cs=%b reg_ce=%b required cs=%b reg_ce=0000",
                             cs_of(sel), ce_of(sel), exp_cs);
                end
            end else begin
                if (cs_of(sel) !== all1 || ce_of(sel) !== exp_ce || wdata_of(sel) !== d) begin
                    n_fail++;
                    $display("FAIL write_enable: cs=%b reg_ce=%b wdata=%h required %b %b %h",
                             cs_of(sel), ce_of(sel), wdata_of(sel), all1, exp_ce, d);
                end
                if (last_tick) tick_early = 1;
                last_tick = tick;
                wcyc++;
            end
        end
        n_tests++;
        if (vld_of(sel) !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", vld_of(sel));
            set_rsp_ready(sel, 1'b0);
            return;
        end
        n_tests++;
        if (!w || is_err) begin
            if (lat != (is_err ? 1 : settle + 2)) begin
                n_fail++;
                $display("FAIL latency: got %0d required %0d", lat, is_err ? 1 : settle + 2);
            end
        end else if (wcyc < 1 || !last_tick || tick_early) begin
            n_fail++;
            $display("FAIL write_tick: cycles=%0d last_tick=%b early=%b required >=1,1,0",
                     wcyc, last_tick, tick_early);
        end
        if (w && !is_err) begin
            if (sel == 0) model_a[a] = d;
            else model_b[a] = d;
        end
        for (int i = 0; i <= hold; i++) begin
            n_tests++;
            if (vld_of(sel) !== 1'b1 || rdata_of(sel) !== exp_rdata || err_of(sel) !== is_err ||
                rdy_of(sel) !== 1'b0 || cs_of(sel) !== all1 || ce_of(sel) !== 4'h0 ||
                (w && !is_err && wdata_of(sel) !== d)) begin
                n_fail++;
                $display("FAIL response: valid=%b rdata=%h err=%b ready=%b cs=%b ce=%b required 1 %h %b 0 %b 0000",
                         vld_of(sel), rdata_of(sel), err_of(sel), rdy_of(sel), cs_of(sel),
                         ce_of(sel), exp_rdata, is_err, all1);
            end
            if (i < hold) @(negedge clk);
        end
        set_rsp_ready(sel, 1'b1);
        @(negedge clk);
        n_tests++;
        if (vld_of(sel) !== 1'b0 || rdy_of(sel) !== 1'b1) begin
            n_fail++;
            $display("FAIL return_idle: rsp_valid=%b req_ready=%b required 0 1",
                     vld_of(sel), rdy_of(sel));
        end
        set_rsp_ready(sel, 1'b0);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (ifa.cs !== 4'hF || ifa.reg_ce !== 4'h0 || ifa.req_ready !== 1'b0 ||
            ifa.rsp_valid !== 1'b0 || ifa.rsp_rdata !== 32'h0 || ifa.rsp_err !== 1'b0 ||
            ifa.bus_wdata !== 32'h0 || ifb.cs !== 3'h7) begin
            n_fail++;
            $display("FAIL reset_values: cs=%b ce=%b rdy=%b vld=%b rdata=%h err=%b wdata=%h required 1111 0000 0 0 0 0 0",
                     ifa.cs, ifa.reg_ce, ifa.req_ready, ifa.rsp_valid, ifa.rsp_rdata,
                     ifa.rsp_err, ifa.bus_wdata);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        env_init = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ifa.req_ready !== 1'b1 || ifb.req_ready !== 1'b1 || ifa.cs !== 4'hF ||
            ifa.reg_ce !== 4'h0) begin
            n_fail++;
            $display("FAIL idle_after_reset: rdy_a=%b rdy_b=%b cs=%b ce=%b required 1 1 1111 0000",
                     ifa.req_ready, ifb.req_ready, ifa.cs, ifa.reg_ce);
        end
    endtask

    task automatic test_read_basic();
        run_txn(0, 1'b1, 2'd2, 32'hDEADBEEF, 0);
        run_txn(0, 1'b0, 2'd2, 32'h0, 0);
    endtask

    task automatic test_write_tick();
        tick_period = 4;
        run_txn(0, 1'b1, 2'd1, 32'h12345678, 0);
        run_txn(0, 1'b1, 2'd3, 32'hA5A5F00D, 2);
        tick_period = 0;
        run_txn(0, 1'b0, 2'd1, 32'h0, 0);
        n_tests++;
        if (env_a[1] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL reg_content: got %h required 12345678", env_a[1]);
        end
    endtask

    task automatic test_addr_error();
        run_txn(1, 1'b0, 2'd3, 32'h0, 0);
        run_txn(1, 1'b1, 2'd3, 32'hFFFF0000, 1);
        run_txn(1, 1'b1, 2'd2, 32'h0BADCAFE, 0);
        run_txn(1, 1'b0, 2'd2, 32'h0, 0);
    endtask

    task automatic test_backpressure();
        run_txn(0, 1'b0, 2'd2, 32'h0, 5);
        run_txn(1, 1'b0, 2'd3, 32'h0, 5);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 2'd3, 32'h0);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 2'd0, 32'h0);
        n_tests++;
        if (ifa.cs !== 4'b0111) begin
            n_fail++;
            $display("FAIL mid_select: cs=%b required 0111", ifa.cs);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ifa.cs !== 4'hF || ifa.rsp_valid !== 1'b0 || ifa.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: cs=%b vld=%b rdy=%b required 1111 0 0",
                     ifa.cs, ifa.rsp_valid, ifa.req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (ifa.rsp_valid !== 1'b0 || ifa.req_ready !== 1'b1 || ifa.cs !== 4'hF) begin
                n_fail++;
                $display("FAIL dropped_req: vld=%b rdy=%b cs=%b required 0 1 1111",
                         ifa.rsp_valid, ifa.req_ready, ifa.cs);
            end
        end
        run_txn(0, 1'b0, 2'd3, 32'h0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            tick_period = $urandom_range(0, 4);
            run_txn(n % 2, 1'($urandom), 2'($urandom_range(0, 3)), $urandom,
                    $urandom_range(0, 3));
        end
        tick_period = 0;
        for (int i = 0; i < 4; i++) run_txn(0, 1'b0, 2'(i), 32'h0, 0);
        for (int i = 0; i < 4; i++) run_txn(1, 1'b0, 2'(i), 32'h0, 1);
    endtask

    task automatic test_protocol();
        n_tests++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL bus_invariants: violations=%0d required 0", viol);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) model_a[i] = 32'h0;
        for (int i = 0; i < 3; i++) model_b[i] = 32'h0;
        drive(0, 1'b0, 1'b0, 2'd0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'd0, 32'h0);
        set_rsp_ready(0, 1'b0);
        set_rsp_ready(1, 1'b0);
        test_reset();
        test_read_basic();
        test_write_tick();
        test_addr_error();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
